// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision field widths, special encodings and the
// built-in (a, b, expected) vector table used by the power-on self check.
package fp32_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned N_TBL = 8;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
    } fp_vec_t;

    // Constant test table; index wraps onto the 8 fixed entries.
    function automatic fp_vec_t get_vec(input logic [IDX_W-1:0] idx);
        fp_vec_t v;
        case (idx)
            3'd0:    v = '{a: 32'h3F80_0000, b: 32'h3F80_0000, expected: 32'h4000_0000};
            3'd1:    v = '{a: 32'h3FC0_0000, b: 32'h4010_0000, expected: 32'h4070_0000};
            3'd2:    v = '{a: 32'h3F80_0000, b: 32'hBF80_0000, expected: 32'h0000_0000};
            3'd3:    v = '{a: 32'h0000_0000, b: 32'h40A0_0000, expected: 32'h40A0_0000};
            3'd4:    v = '{a: 32'hC020_0000, b: 32'h3F80_0000, expected: 32'hBFC0_0000};
            3'd5:    v = '{a: 32'h3F80_0000, b: 32'h3380_0000, expected: 32'h3F80_0000};
            3'd6:    v = '{a: 32'h7F7F_FFFF, b: 32'h7F7F_FFFF, expected: 32'h7F80_0000};
            default: v = '{a: 32'h42C8_0000, b: 32'h3F00_0000, expected: 32'h42C9_0000};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/fp_add32.sv
// Combinational single-precision adder: RNE rounding, flush-to-zero on
// subnormal inputs/results, IEEE signed-zero, infinity and NaN handling.
module fp_add32
    import fp32_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum_c
);

    localparam int unsigned EXT_W = MAN_W + 4;   // hidden + mantissa + G/R/S
    localparam int unsigned SH_W  = 2*MAN_W + 4;

    logic             w_sa, w_sb, w_sl;
    logic [EXP_W-1:0] w_ea, w_eb, w_el, w_es;
    logic [MAN_W-1:0] w_fa, w_fb, w_fl, w_fs;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic             w_swap;
    logic [EXP_W:0]   w_diff;
    logic [SH_W-1:0]  w_sh;
    logic [EXT_W-1:0] w_l_ext, w_s_ext, w_norm;
    logic [EXT_W:0]   w_raw;
    logic [4:0]       w_lz;
    logic signed [9:0] w_exp_n, w_exp_r;
    logic             w_round_up;
    logic [MAN_W+1:0] w_mr;
    logic [MAN_W-1:0] w_frac;
    logic [31:0]      w_gen;

    assign w_sa     = i_a[31];
    assign w_sb     = i_b[31];
    assign w_ea     = i_a[30:23];
    assign w_eb     = i_b[30:23];
    assign w_fa     = i_a[22:0];
    assign w_fb     = i_b[22:0];
    assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
    assign w_b_nan  = (w_eb == '1) && (w_fb != '0);
    assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
    assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_swap   = (i_b[30:0] > i_a[30:0]);

    // General finite path: align, add/subtract, normalise, round.
    always_comb begin
        w_sl       = w_swap ? w_sb : w_sa;
        w_el       = w_swap ? w_eb : w_ea;
        w_es       = w_swap ? w_ea : w_eb;
        w_fl       = w_swap ? w_fb : w_fa;
        w_fs       = w_swap ? w_fa : w_fb;
        w_diff     = {1'b0, w_el} - {1'b0, w_es};
        w_l_ext    = {1'b1, w_fl, 3'b000};
        w_sh       = '0;
        w_s_ext    = EXT_W'(1);
        w_raw      = '0;
        w_norm     = '0;
        w_lz       = '0;
        w_exp_n    = '0;
        w_exp_r    = '0;
        w_round_up = 1'b0;
        w_mr       = '0;
        w_frac     = '0;
        w_gen      = '0;

        // Shifts of 25+ leave only a sticky bit.
        if (w_diff < 9'd25) begin
            w_sh    = {1'b1, w_fs, (SH_W-MAN_W-1)'(0)} >> w_diff;
            w_s_ext = {w_sh[SH_W-1:SH_W-EXT_W+1], |w_sh[SH_W-EXT_W:0]};
        end

        if (w_sa == w_sb) w_raw = {1'b0, w_l_ext} + {1'b0, w_s_ext};
        else              w_raw = {1'b0, w_l_ext} - {1'b0, w_s_ext};

        for (int i = 0; i < EXT_W; i++) begin
            if (w_raw[i]) w_lz = 5'(EXT_W - 1 - i);
        end

        if (w_raw[EXT_W]) begin
            w_norm  = {w_raw[EXT_W:2], w_raw[1] | w_raw[0]};
            w_exp_n = $signed({2'b00, w_el}) + 10'sd1;
        end else begin
            w_norm  = w_raw[EXT_W-1:0] << w_lz;
            w_exp_n = $signed({2'b00, w_el}) - $signed({5'b00000, w_lz});
        end

        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mr       = {1'b0, w_norm[EXT_W-1:3]} + (MAN_W+2)'(w_round_up);
        w_exp_r    = w_mr[MAN_W+1] ? (w_exp_n + 10'sd1) : w_exp_n;
        w_frac     = w_mr[MAN_W+1] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];

        if (w_raw == '0)           w_gen = 32'h0000_0000;
        else if (w_exp_r >= 10'sd255) w_gen = {w_sl, POS_INF[30:0]};
        else if (w_exp_r <= 10'sd0)   w_gen = {w_sl, 31'h0};
        else                       w_gen = {w_sl, w_exp_r[7:0], w_frac};
    end

    // Special operands take priority over the arithmetic path.
    always_comb begin
        o_sum_c = w_gen;
        if (w_a_nan || w_b_nan)                       o_sum_c = QNAN;
        else if (w_a_inf && w_b_inf && (w_sa != w_sb)) o_sum_c = QNAN;
        else if (w_a_inf)                             o_sum_c = {w_sa, POS_INF[30:0]};
        else if (w_b_inf)                             o_sum_c = {w_sb, POS_INF[30:0]};
        else if (w_a_zero && w_b_zero)                o_sum_c = {w_sa & w_sb, 31'h0};
        else if (w_a_zero)                            o_sum_c = i_b;
        else if (w_b_zero)                            o_sum_c = i_a;
    end

endmodule

// File: rtl/fpga_fp_check.sv
// Power-on self check: steps the constant vector table through fp_add32 one
// entry per cycle and latches a pass/fail LED pair once the table is done.
module fpga_fp_check
    import fp32_pkg::*;
#(
    parameter int unsigned N_VEC       = 8,
    parameter int unsigned FAIL_INJECT = 0
) (
    input  logic clk,
    input  logic rst_n,
    output logic led_correct,
    output logic led_incorrect
);

    typedef enum logic [1:0] {ST_PEND, ST_RUN, ST_DONE} state_t;

    state_t           r_state, w_state_nx;
    logic [IDX_W-1:0] r_idx, w_idx_nx;
    logic             r_mismatch, w_mismatch_nx;
    logic             r_led_correct, w_led_correct_nx;
    logic             r_led_incorrect, w_led_incorrect_nx;

    fp_vec_t          w_vec;
    logic [31:0]      w_sum;
    logic [31:0]      w_expected;
    logic             w_miss;
    logic             w_inject;

    assign w_vec      = get_vec(r_idx);
    assign w_inject   = (FAIL_INJECT != 0) && (r_idx == '0);
    assign w_expected = w_vec.expected ^ {31'h0, w_inject};
    assign w_miss     = (w_sum != w_expected);

    fp_add32 u_add (
        .i_a     (w_vec.a),
        .i_b     (w_vec.b),
        .o_sum_c (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_PEND;
            r_idx           <= '0;
            r_mismatch      <= 1'b0;
            r_led_correct   <= 1'b0;
            r_led_incorrect <= 1'b0;
        end else begin
            r_state         <= w_state_nx;
            r_idx           <= w_idx_nx;
            r_mismatch      <= w_mismatch_nx;
            r_led_correct   <= w_led_correct_nx;
            r_led_incorrect <= w_led_incorrect_nx;
        end
    end

    // The last compare folds directly into the LED update on the DONE edge.
    always_comb begin
        w_state_nx         = r_state;
        w_idx_nx           = r_idx;
        w_mismatch_nx      = r_mismatch;
        w_led_correct_nx   = r_led_correct;
        w_led_incorrect_nx = r_led_incorrect;
        case (r_state)
            ST_PEND: begin
                w_state_nx = ST_RUN;
                w_idx_nx   = '0;
            end
            ST_RUN: begin
                w_mismatch_nx = r_mismatch | w_miss;
                if (r_idx == IDX_W'(N_VEC - 1)) begin
                    w_state_nx         = ST_DONE;
                    w_led_correct_nx   = ~(r_mismatch | w_miss);
                    w_led_incorrect_nx = r_mismatch | w_miss;
                end else begin
                    w_idx_nx = r_idx + IDX_W'(1);
                end
            end
            default: w_state_nx = ST_DONE;
        endcase
    end

    assign led_correct   = r_led_correct;
    assign led_incorrect = r_led_incorrect;

endmodule

// File: tb/tb_fpga_fp_check.sv
// Bench for fpga_fp_check (nominal, fail-injected and short-table builds)
// and direct vectors for the fp_add32 adder.
module tb_fpga_fp_check;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c8, i8, cinj, iinj, c3, i3;
    logic [31:0] add_a, add_b, add_sum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fpga_fp_check #(.N_VEC(8), .FAIL_INJECT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .led_correct(c8), .led_incorrect(i8));
    fpga_fp_check #(.N_VEC(8), .FAIL_INJECT(1)) u_dut_inj (
        .clk(clk), .rst_n(rst_n), .led_correct(cinj), .led_incorrect(iinj));
    fpga_fp_check #(.N_VEC(3), .FAIL_INJECT(0)) u_dut_n3 (
        .clk(clk), .rst_n(rst_n), .led_correct(c3), .led_incorrect(i3));
    fp_add32 u_add (.i_a(add_a), .i_b(add_b), .o_sum_c(add_sum));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
    } add_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_leds_low(input string tag);
        check($sformatf("%s n8 leds", tag), {30'h0, c8, i8}, 32'h0);
        check($sformatf("%s inj leds", tag), {30'h0, cinj, iinj}, 32'h0);
        check($sformatf("%s n3 leds", tag), {30'h0, c3, i3}, 32'h0);
    endtask

    // Edge k counts rising edges after release; LED values follow from k alone.
    task automatic run_edges(input string tag, input int edges);
        for (int k = 1; k <= edges; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s edge%0d n8", tag, k), {30'h0, c8, i8},
                  (k >= 9) ? 32'h2 : 32'h0);
            check($sformatf("%s edge%0d inj", tag, k), {30'h0, cinj, iinj},
                  (k >= 9) ? 32'h1 : 32'h0);
            check($sformatf("%s edge%0d n3", tag, k), {30'h0, c3, i3},
                  (k >= 4) ? 32'h2 : 32'h0);
        end
    endtask

    add_vec_t vecs[24];

    initial begin
        vecs[0]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000};
        vecs[1]  = '{32'h3FC0_0000, 32'h4010_0000, 32'h4070_0000};
        vecs[2]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000};
        vecs[3]  = '{32'h0000_0000, 32'h40A0_0000, 32'h40A0_0000};
        vecs[4]  = '{32'hC020_0000, 32'h3F80_0000, 32'hBFC0_0000};
        vecs[5]  = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
        vecs[6]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000};
        vecs[7]  = '{32'h42C8_0000, 32'h3F00_0000, 32'h42C9_0000};
        vecs[8]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000};
        vecs[9]  = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000};
        vecs[10] = '{32'h0040_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001};
        vecs[12] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        vecs[13] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
        vecs[14] = '{32'hFF7F_FFFF, 32'hFF7F_FFFF, 32'hFF80_0000};
        vecs[15] = '{32'h7F80_0000, 32'hC040_0000, 32'h7F80_0000};
        vecs[16] = '{32'hC040_0000, 32'hFF80_0000, 32'hFF80_0000};
        vecs[17] = '{32'h3F80_0000, 32'hFFC0_0000, 32'h7FC0_0000};
        vecs[18] = '{32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000};
        vecs[19] = '{32'h3F80_0000, 32'hB380_0000, 32'h3F7F_FFFF};
        vecs[20] = '{32'h0080_0001, 32'h8080_0000, 32'h0000_0000};
        vecs[21] = '{32'h8080_0001, 32'h0080_0000, 32'h8000_0000};
        vecs[22] = '{32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002};
        vecs[23] = '{32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000};

        add_a = '0;
        add_b = '0;

        // Reset held, then three cycles low before release.
        #1;
        check_leds_low("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_edges("power-on", 29);

        // Reset in DONE clears the LEDs without waiting for a clock.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_leds_low("async-in-done");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_edges("restart", 4);

        // Reset mid-RUN for two cycles, then a full clean pass.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_leds_low("mid-run");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_leds_low("mid-run-held");
        rst_n = 1'b1;
        run_edges("after-abort", 12);

        for (int i = 0; i < 24; i++) begin
            add_a = vecs[i].a;
            add_b = vecs[i].b;
            #1;
            check($sformatf("add[%0d] %h+%h", i, vecs[i].a, vecs[i].b), add_sum, vecs[i].expected);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Never both LEDs lit on any instance.
    always @(negedge clk) begin
        if ((c8 & i8) | (cinj & iinj) | (c3 & i3)) begin
            n_checks++;
            n_errors++;
            $display("FAIL both-leds: got %b%b/%b%b/%b%b required not both high",
                     c8, i8, cinj, iinj, c3, i3);
        end
    end

endmodule

// File: doc/fpga_fp_check.md
FPGA_FP_CHECK -- requirements
Module: fpga_fp_check

Interface
REQ-001 Parameter N_VEC, default 8: number of built-in test vectors; fixed table, range 1..8.
REQ-002 Parameter FAIL_INJECT, default 0: when 1, bit 0 of vector 0's expected result SHALL be inverted (self-test of the failure path).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 led_correct  output  1  high once all vectors have completed with every sum matching its expected value.
REQ-006 led_incorrect  output  1  high once all vectors have completed with at least one mismatch.

Function
REQ-007 Block SHALL apply a constant table of (a, b, expected) IEEE-754 single-precision triples to a combinational FP adder and compare the sum to expected, bit-exact.
REQ-008 Table:
- v0: 3F800000 + 3F800000 = 40000000
- v1: 3FC00000 + 40100000 = 40700000
- v2: 3F800000 + BF800000 = 00000000
- v3: 00000000 + 40A00000 = 40A00000
- v4: C0200000 + 3F800000 = BFC00000
- v5: 3F800000 + 33800000 = 3F800000 (tie to even)
- v6: 7F7FFFFF + 7F7FFFFF = 7F800000
- v7: 42C80000 + 3F000000 = 42C90000
REQ-009 FSM states:
- RUN: entered on first edge after reset release; one vector per cycle, index 0..N_VEC-1.
- DONE: entered after the last compare; held until reset.
REQ-010 Sticky mismatch flag SHALL be set on any compare failure and never cleared except by reset.
REQ-011 Latency: outputs valid on the (N_VEC+1)th rising edge after rst_n deasserts (9 edges for N_VEC=8), registered.
REQ-012 In DONE exactly one of led_correct and led_incorrect SHALL be high; both SHALL be low in reset and in RUN.
REQ-013 Adder rounding: round-to-nearest-even, using guard, round and sticky bits.
REQ-014 Adder subnormals: inputs are flushed to zero; results below the minimum normal are flushed to zero with the correct sign.
REQ-015 Adder signed zero: exact cancellation SHALL yield +0; (-0)+(-0) SHALL yield -0.
REQ-016 Adder overflow SHALL yield correctly signed infinity.
REQ-017 Adder special inputs:
- NaN input, or +Inf plus -Inf, SHALL yield 7FC00000.
- Inf plus a finite value SHALL yield that Inf.
REQ-018 Adder normalisation SHALL handle a carry-out (right shift by 1) and leading-zero cancellation (left shift by 0..24) via a priority encoder.
REQ-019 Exponent difference of 25 or more SHALL shift the smaller operand fully into sticky.
REQ-020 Reset asserted mid-RUN or in DONE SHALL abort, clear all state, and restart from v0 on release.

Reset
REQ-021 rst_n low SHALL asynchronously force:
- state = RUN-pending
- index = 0
- mismatch flag = 0
- led_correct = 0, led_incorrect = 0
REQ-022 Reset release SHALL be treated synchronously: RUN begins on the first rising edge with rst_n high.

Structure
REQ-023 Shared package fp32_pkg SHALL hold:
- field widths: EXP_W=8, MAN_W=23, BIAS=127
- constants: QNAN=7FC00000, POS_INF=7F800000
- vector-triple typedef and the test table
REQ-024 Single sub-module fp_add32 (combinational, a, b -> sum) SHALL contain all arithmetic; fpga_fp_check holds only the FSM, index, compare and LED registers.

Verification
REQ-025 Reset low 3 cycles, release, FAIL_INJECT=0 -> led_correct=1, led_incorrect=0 on the 9th edge, stable for 20 further cycles.
REQ-026 FAIL_INJECT=1 -> led_correct=0, led_incorrect=1 on the 9th edge.
REQ-027 Assert rst_n low at cycle 4 of RUN for 2 cycles -> both LEDs 0 at once; led_correct=1 again 9 edges after release.
REQ-028 fp_add32 standalone:
- 7FC00001+3F800000 -> 7FC00000
- 7F800000+FF800000 -> 7FC00000
- 00400000+00000000 -> 00000000
- 3F800000+33800001 -> 3F800001
REQ-029 Both LEDs SHALL be 0 at every cycle before the 9th edge, and never both 1 at any time.
